// File: rtl/dx_stage_pkg.sv
// rtl/dx_stage_pkg.sv - shared cpu types: condition codes, flag indices, E control bundle
package dx_stage_pkg;

    typedef enum logic [3:0] {
        COND_EQ = 4'b0000,
        COND_NE = 4'b0001,
        COND_CS = 4'b0010,
        COND_CC = 4'b0011,
        COND_MI = 4'b0100,
        COND_PL = 4'b0101,
        COND_VS = 4'b0110,
        COND_VC = 4'b0111,
        COND_HI = 4'b1000,
        COND_LS = 4'b1001,
        COND_GE = 4'b1010,
        COND_LT = 4'b1011,
        COND_GT = 4'b1100,
        COND_LE = 4'b1101,
        COND_AL = 4'b1110,
        COND_NV = 4'b1111
    } cond_t;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    typedef struct packed {
        logic       regWrite;
        logic       memWrite;
        logic       memToReg;
        logic       branch;
        logic       pcSrc;
        logic       aluSrc;
        logic [1:0] flagWrite;
        logic [1:0] aluControl;
        cond_t      cond;
    } e_ctrl_t;

    // A bubble executes unconditionally but does nothing observable.
    localparam e_ctrl_t BUBBLE_CTRL = '{
        regWrite:   1'b0,
        memWrite:   1'b0,
        memToReg:   1'b0,
        branch:     1'b0,
        pcSrc:      1'b0,
        aluSrc:     1'b0,
        flagWrite:  2'b00,
        aluControl: 2'b00,
        cond:       COND_AL
    };

endpackage

// File: rtl/dx_stage_cond_check.sv
// rtl/dx_stage_cond_check.sv - combinational ARM condition evaluation against NZCV
module cond_check
    import dx_stage_pkg::*;
(
    input  logic [3:0] CondE,
    input  logic [3:0] FlagsE,
    output logic       CondExE
);

    logic n, z, c, v;

    assign n = FlagsE[FLAG_N];
    assign z = FlagsE[FLAG_Z];
    assign c = FlagsE[FLAG_C];
    assign v = FlagsE[FLAG_V];

    always_comb begin
        CondExE = 1'b1;
        case (cond_t'(CondE))
            COND_EQ: CondExE = z;
            COND_NE: CondExE = !z;
            COND_CS: CondExE = c;
            COND_CC: CondExE = !c;
            COND_MI: CondExE = n;
            COND_PL: CondExE = !n;
            COND_VS: CondExE = v;
            COND_VC: CondExE = !v;
            COND_HI: CondExE = c && !z;
            COND_LS: CondExE = !c || z;
            COND_GE: CondExE = (n == v);
            COND_LT: CondExE = (n != v);
            COND_GT: CondExE = !z && (n == v);
            COND_LE: CondExE = z || (n != v);
            default: CondExE = 1'b1;
        endcase
    end

endmodule

// File: rtl/dx_stage.sv
// rtl/dx_stage.sv - D/E pipeline register, NZCV flags and condition gating
module dx_stage
    import dx_stage_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              FlushE,
    input  logic [DATA_W-1:0] RD1D,
    input  logic [DATA_W-1:0] RD2D,
    input  logic [DATA_W-1:0] ExtImmD,
    input  logic [ADDR_W-1:0] RA1D,
    input  logic [ADDR_W-1:0] RA2D,
    input  logic [ADDR_W-1:0] WA3D,
    input  logic              RegWriteD,
    input  logic              MemWriteD,
    input  logic              MemToRegD,
    input  logic              BranchD,
    input  logic              PCSrcD,
    input  logic              ALUSrcD,
    input  logic [1:0]        ALUControlD,
    input  logic [1:0]        FlagWriteD,
    input  logic [3:0]        CondD,
    input  logic [3:0]        ALUFlagsE,
    output logic [DATA_W-1:0] RD1E,
    output logic [DATA_W-1:0] RD2E,
    output logic [DATA_W-1:0] ExtImmE,
    output logic [ADDR_W-1:0] RA1E,
    output logic [ADDR_W-1:0] RA2E,
    output logic [ADDR_W-1:0] WA3E,
    output logic [1:0]        ALUControlE,
    output logic              ALUSrcE,
    output logic              MemToRegE,
    output logic              RegWriteE,
    output logic              MemWriteE,
    output logic              PCSrcE,
    output logic              BranchTakenE,
    output logic              CondExE,
    output logic [3:0]        FlagsE
);

    e_ctrl_t ctrlE;

    always_ff @(posedge clk) begin
        if (reset || FlushE) begin
            ctrlE   <= BUBBLE_CTRL;
            RD1E    <= '0;
            RD2E    <= '0;
            ExtImmE <= '0;
            RA1E    <= '0;
            RA2E    <= '0;
            WA3E    <= '0;
        end else begin
            ctrlE <= '{
                regWrite:   RegWriteD,
                memWrite:   MemWriteD,
                memToReg:   MemToRegD,
                branch:     BranchD,
                pcSrc:      PCSrcD,
                aluSrc:     ALUSrcD,
                flagWrite:  FlagWriteD,
                aluControl: ALUControlD,
                cond:       cond_t'(CondD)
            };
            RD1E    <= RD1D;
            RD2E    <= RD2D;
            ExtImmE <= ExtImmD;
            RA1E    <= RA1D;
            RA2E    <= RA2D;
            WA3E    <= WA3D;
        end
    end

    // Flags follow the instruction already in E, so a flush arriving this cycle does not cancel them.
    always_ff @(posedge clk) begin
        if (reset) begin
            FlagsE <= '0;
        end else begin
            if (CondExE && ctrlE.flagWrite[1]) begin
                FlagsE[FLAG_N] <= ALUFlagsE[FLAG_N];
                FlagsE[FLAG_Z] <= ALUFlagsE[FLAG_Z];
            end
            if (CondExE && ctrlE.flagWrite[0]) begin
                FlagsE[FLAG_C] <= ALUFlagsE[FLAG_C];
                FlagsE[FLAG_V] <= ALUFlagsE[FLAG_V];
            end
        end
    end

    cond_check u_cond_check (
        .CondE   (ctrlE.cond),
        .FlagsE  (FlagsE),
        .CondExE (CondExE)
    );

    assign ALUControlE  = ctrlE.aluControl;
    assign ALUSrcE      = ctrlE.aluSrc;
    assign MemToRegE    = ctrlE.memToReg;
    assign RegWriteE    = ctrlE.regWrite && CondExE;
    assign MemWriteE    = ctrlE.memWrite && CondExE;
    assign PCSrcE       = ctrlE.pcSrc && CondExE;
    assign BranchTakenE = ctrlE.branch && CondExE;

endmodule

// File: tb/tb_dx_stage.sv
// tb/tb_dx_stage.sv - directed self-checking bench for dx_stage
module tb_dx_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        FlushE;
    logic [31:0] RD1D, RD2D, ExtImmD;
    logic [5:0]  RA1D, RA2D, WA3D;
    logic        RegWriteD, MemWriteD, MemToRegD, BranchD, PCSrcD, ALUSrcD;
    logic [1:0]  ALUControlD, FlagWriteD;
    logic [3:0]  CondD, ALUFlagsE;
    logic [31:0] RD1E, RD2E, ExtImmE;
    logic [5:0]  RA1E, RA2E, WA3E;
    logic [1:0]  ALUControlE;
    logic        ALUSrcE, MemToRegE, RegWriteE, MemWriteE, PCSrcE, BranchTakenE, CondExE;
    logic [3:0]  FlagsE;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    dx_stage #(.DATA_W(32), .ADDR_W(6)) dut (
        .clk(clk), .reset(reset), .FlushE(FlushE),
        .RD1D(RD1D), .RD2D(RD2D), .ExtImmD(ExtImmD),
        .RA1D(RA1D), .RA2D(RA2D), .WA3D(WA3D),
        .RegWriteD(RegWriteD), .MemWriteD(MemWriteD), .MemToRegD(MemToRegD),
        .BranchD(BranchD), .PCSrcD(PCSrcD), .ALUSrcD(ALUSrcD),
        .ALUControlD(ALUControlD), .FlagWriteD(FlagWriteD), .CondD(CondD),
        .ALUFlagsE(ALUFlagsE),
        .RD1E(RD1E), .RD2E(RD2E), .ExtImmE(ExtImmE),
        .RA1E(RA1E), .RA2E(RA2E), .WA3E(WA3E),
        .ALUControlE(ALUControlE), .ALUSrcE(ALUSrcE), .MemToRegE(MemToRegE),
        .RegWriteE(RegWriteE), .MemWriteE(MemWriteE), .PCSrcE(PCSrcE),
        .BranchTakenE(BranchTakenE), .CondExE(CondExE), .FlagsE(FlagsE)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic nop_d();
        RD1D = '0; RD2D = '0; ExtImmD = '0;
        RA1D = '0; RA2D = '0; WA3D = '0;
        RegWriteD = 0; MemWriteD = 0; MemToRegD = 0; BranchD = 0; PCSrcD = 0; ALUSrcD = 0;
        ALUControlD = 2'b00; FlagWriteD = 2'b00; CondD = 4'b1110;
    endtask

    task automatic test_reset();
        reset = 1; FlushE = 0;
        RD1D = $urandom; RD2D = $urandom; ExtImmD = $urandom;
        RA1D = 6'($urandom); RA2D = 6'($urandom); WA3D = 6'($urandom);
        {RegWriteD, MemWriteD, MemToRegD, BranchD, PCSrcD, ALUSrcD} = 6'b111111;
        ALUControlD = 2'b11; FlagWriteD = 2'b11; CondD = 4'b1110; ALUFlagsE = 4'b1111;
        tick();
        tick();
        checks++;
        if ({RD1E, RD2E, ExtImmE} !== 96'd0) begin
            errors++; $display("FAIL reset_data: got %h %h %h want 0", RD1E, RD2E, ExtImmE);
        end
        checks++;
        if ({RA1E, RA2E, WA3E, ALUControlE, ALUSrcE, MemToRegE} !== 22'd0) begin
            errors++; $display("FAIL reset_addr_ctrl: got %h want 0", {RA1E, RA2E, WA3E, ALUControlE, ALUSrcE, MemToRegE});
        end
        checks++;
        if ({RegWriteE, MemWriteE, PCSrcE, BranchTakenE} !== 4'b0000) begin
            errors++; $display("FAIL reset_gated: got %b want 0000", {RegWriteE, MemWriteE, PCSrcE, BranchTakenE});
        end
        checks++;
        if (FlagsE !== 4'b0000) begin
            errors++; $display("FAIL reset_flags: got %b want 0000", FlagsE);
        end
        checks++;
        if (CondExE !== 1'b1) begin
            errors++; $display("FAIL reset_condex: got %b want 1", CondExE);
        end
        reset = 0; ALUFlagsE = 4'b0000;
    endtask

    task automatic test_capture();
        nop_d();
        RegWriteD = 1; WA3D = 6'd5; RA1D = 6'd1; RA2D = 6'd2;
        RD1D = 32'hDEAD_0001; RD2D = 32'h0000_BEEF; ExtImmD = 32'h0000_00FF;
        ALUControlD = 2'b10; ALUSrcD = 1; MemToRegD = 1;
        tick();
        checks++;
        if ({RegWriteE, WA3E, RA1E, RA2E} !== {1'b1, 6'd5, 6'd1, 6'd2}) begin
            errors++; $display("FAIL capture_regs: got %b %0d %0d %0d want 1 5 1 2", RegWriteE, WA3E, RA1E, RA2E);
        end
        checks++;
        if ({RD1E, RD2E, ExtImmE} !== {32'hDEAD_0001, 32'h0000_BEEF, 32'h0000_00FF}) begin
            errors++; $display("FAIL capture_data: got %h %h %h", RD1E, RD2E, ExtImmE);
        end
        checks++;
        if ({ALUControlE, ALUSrcE, MemToRegE, MemWriteE} !== 5'b10110) begin
            errors++; $display("FAIL capture_ctrl: got %b want 10110", {ALUControlE, ALUSrcE, MemToRegE, MemWriteE});
        end
    endtask

    task automatic test_flush();
        nop_d();
        RegWriteD = 1; BranchD = 1; PCSrcD = 1; WA3D = 6'd9; RD1D = 32'h1234_5678;
        FlushE = 1;
        tick();
        FlushE = 0;
        checks++;
        if ({RegWriteE, BranchTakenE, PCSrcE, WA3E, RD1E} !== 41'd0) begin
            errors++; $display("FAIL flush_bubble: got %b %b %b %0d %h want all 0", RegWriteE, BranchTakenE, PCSrcE, WA3E, RD1E);
        end
        checks++;
        if (CondExE !== 1'b1) begin
            errors++; $display("FAIL flush_condex: got %b want 1", CondExE);
        end
    endtask

    task automatic cmp_beq(input logic [3:0] aluFlags, input logic expTaken, input string name);
        nop_d();
        FlagWriteD = 2'b11;
        tick();
        ALUFlagsE = aluFlags;
        nop_d();
        BranchD = 1; CondD = 4'b0000;
        tick();
        ALUFlagsE = 4'b0000;
        checks++;
        if (FlagsE !== aluFlags) begin
            errors++; $display("FAIL %s_flags: got %b want %b", name, FlagsE, aluFlags);
        end
        checks++;
        if (BranchTakenE !== expTaken) begin
            errors++; $display("FAIL %s_taken: got %b want %b", name, BranchTakenE, expTaken);
        end
    endtask

    task automatic test_back_to_back();
        cmp_beq(4'b0100, 1'b1, "beq_z1");
        cmp_beq(4'b0000, 1'b0, "beq_z0");
    endtask

    task automatic test_cond_fail();
        nop_d();
        CondD = 4'b0000; FlagWriteD = 2'b11; MemWriteD = 1;
        tick();
        checks++;
        if ({MemWriteE, CondExE} !== 2'b00) begin
            errors++; $display("FAIL condfail_gate: got memwrite=%b condex=%b want 0 0", MemWriteE, CondExE);
        end
        ALUFlagsE = 4'b1111;
        nop_d();
        tick();
        ALUFlagsE = 4'b0000;
        checks++;
        if (FlagsE !== 4'b0000) begin
            errors++; $display("FAIL condfail_flags: got %b want 0000", FlagsE);
        end
    endtask

    task automatic test_flush_flags();
        nop_d();
        FlagWriteD = 2'b11;
        tick();
        ALUFlagsE = 4'b1001;
        nop_d();
        RegWriteD = 1; WA3D = 6'd3;
        FlushE = 1;
        tick();
        FlushE = 0; ALUFlagsE = 4'b0000;
        checks++;
        if (FlagsE !== 4'b1001) begin
            errors++; $display("FAIL flushflags_flags: got %b want 1001", FlagsE);
        end
        checks++;
        if ({RegWriteE, WA3E} !== 7'd0) begin
            errors++; $display("FAIL flushflags_bubble: got %b %0d want 0 0", RegWriteE, WA3E);
        end
    endtask

    // Flags are N=1 Z=0 C=0 V=1 here.
    task automatic test_cond_codes();
        logic [3:0] conds [10];
        logic       exp   [10];
        conds = '{4'b1010, 4'b1011, 4'b1100, 4'b1101, 4'b0100, 4'b0101, 4'b0110, 4'b1000, 4'b1001, 4'b1111};
        exp   = '{1'b1,    1'b0,    1'b1,    1'b0,    1'b1,    1'b0,    1'b1,    1'b0,    1'b1,    1'b1};
        for (int i = 0; i < 10; i++) begin
            nop_d();
            RegWriteD = 1; CondD = conds[i];
            tick();
            checks++;
            if (RegWriteE !== exp[i]) begin
                errors++; $display("FAIL cond_%b: got %b want %b", conds[i], RegWriteE, exp[i]);
            end
        end
    endtask

    task automatic test_partial_flags();
        nop_d();
        FlagWriteD = 2'b01;
        tick();
        ALUFlagsE = 4'b0110;
        nop_d();
        tick();
        ALUFlagsE = 4'b0000;
        checks++;
        if (FlagsE !== 4'b1010) begin
            errors++; $display("FAIL partial_flags: got %b want 1010", FlagsE);
        end
        nop_d();
        FlagWriteD = 2'b10;
        tick();
        ALUFlagsE = 4'b0111;
        nop_d();
        tick();
        ALUFlagsE = 4'b0000;
        checks++;
        if (FlagsE !== 4'b0110) begin
            errors++; $display("FAIL partial_nz: got %b want 0110", FlagsE);
        end
    endtask

    initial begin
        test_reset();
        test_capture();
        test_flush();
        test_back_to_back();
        test_cond_fail();
        test_flush_flags();
        test_cond_codes();
        test_partial_flags();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
